// File: rtl/uart_wb_master.sv
// uart_wb_master: 8N1 serial command bridge issuing single 32-bit Wishbone classic cycles.
// Define UART_WB_MASTER_TIMEOUT_EN to abort bus cycles after BUS_TIMEOUT clocks with status 0x02.
module uart_wb_master #(
  parameter int SYS_CLK_FREQ = 40000000,
  parameter int BAUD         = 9600,
  parameter int CLK_DIVIDER  = SYS_CLK_FREQ / BAUD,
  parameter int BUS_TIMEOUT  = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        busy_o
);
  localparam int CW = $clog2(CLK_DIVIDER);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIVIDER - 1);
  localparam logic [CW-1:0] DIV_MID  = CW'((CLK_DIVIDER - 1) / 2);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BRK} rx_state_t;
  typedef enum logic [2:0] {S_CMD, S_ADR, S_DAT, S_BUS, S_RESP} state_t;

  rx_state_t   r_rx_state;
  logic        r_rx_meta, r_rx_sync, r_rx_valid, r_rx_ferr;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_sh;

  state_t      r_state;
  logic [1:0]  r_idx;
  logic        r_write, r_cyc, r_we, r_tx, r_busy;
  logic [31:0] r_adr, r_dat, r_rdat;
  logic [2:0]  r_nb;
  logic [9:0]  r_tx_sh;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]  r_tx_bit;
  logic        w_tmo, w_done;
  logic [7:0]  w_status;

  assign tx_o      = r_tx;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = {4{r_cyc}};
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign busy_o    = r_busy;
  // err wins over a simultaneous ack; timeout only when the slave stays silent
  assign w_status  = wbm_err_i ? 8'h01 : (wbm_ack_i ? 8'h00 : 8'h02);
  assign w_done    = wbm_ack_i | wbm_err_i | w_tmo;

`ifdef UART_WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(BUS_TIMEOUT + 1);
  logic [TW-1:0] r_tmo;
  assign w_tmo = (r_tmo == TW'(BUS_TIMEOUT - 1));
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) r_tmo <= '0;
    else r_tmo <= (r_state == S_BUS) ? r_tmo + 1'b1 : '0;
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_meta  <= rx_i;
      r_rx_sync  <= r_rx_meta;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: if (!r_rx_sync) begin
          r_rx_cnt   <= '0;
          r_rx_state <= RX_START;
        end
        RX_START: if (r_rx_cnt == DIV_MID) begin
          r_rx_cnt   <= '0;
          r_rx_bit   <= '0;
          r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        RX_DATA: if (r_rx_cnt == DIV_LAST) begin
          r_rx_cnt <= '0;
          r_rx_sh  <= {r_rx_sync, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 1'b1;
          if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        RX_STOP: if (r_rx_cnt == DIV_LAST) begin
          r_rx_valid <= r_rx_sync;
          r_rx_ferr  <= !r_rx_sync;
          r_rx_state <= r_rx_sync ? RX_IDLE : RX_BRK;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        // a low stop bit must see the line go high before hunting for a new start
        RX_BRK: if (r_rx_sync) r_rx_state <= RX_IDLE;
        default: r_rx_state <= RX_IDLE;
      endcase
    end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      r_state  <= S_CMD;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_cyc    <= 1'b0;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_rdat   <= '0;
      r_nb     <= '0;
      r_tx     <= 1'b1;
      r_tx_sh  <= '1;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_CMD: if (r_rx_valid) begin
          r_busy <= 1'b1;
          if (r_rx_sh == 8'h01 || r_rx_sh == 8'h02) begin
            r_write <= (r_rx_sh == 8'h01);
            r_idx   <= '0;
            r_state <= S_ADR;
          end else begin
            r_tx_sh  <= {1'b1, 8'h03, 1'b0};
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_nb     <= '0;
            r_state  <= S_RESP;
          end
        end
        S_ADR, S_DAT: if (r_rx_ferr) begin
          r_busy  <= 1'b0;
          r_state <= S_CMD;
        end else if (r_rx_valid) begin
          if (r_state == S_ADR) r_adr <= {r_adr[23:0], r_rx_sh};
          else r_dat <= {r_dat[23:0], r_rx_sh};
          r_idx <= r_idx + 1'b1;
          if (r_idx == 2'd3) begin
            if (r_state == S_ADR && r_write) r_state <= S_DAT;
            else begin
              r_cyc   <= 1'b1;
              r_we    <= r_write;
              r_state <= S_BUS;
            end
          end
        end
        S_BUS: if (w_done) begin
          r_cyc    <= 1'b0;
          r_we     <= 1'b0;
          r_rdat   <= wbm_dat_i;
          r_nb     <= (wbm_ack_i && !wbm_err_i && !r_we) ? 3'd4 : 3'd0;
          r_tx_sh  <= {1'b1, w_status, 1'b0};
          r_tx_cnt <= '0;
          r_tx_bit <= '0;
          r_state  <= S_RESP;
        end
        // each bit is driven when the counter wraps to 0; bit 10 means the stop bit has ended
        S_RESP: if (r_tx_cnt == '0) begin
          if (r_tx_bit == 4'd10) begin
            if (r_nb != '0) begin
              r_tx_sh  <= {1'b1, r_rdat[31:24], 1'b0};
              r_rdat   <= {r_rdat[23:0], 8'h00};
              r_nb     <= r_nb - 1'b1;
              r_tx_bit <= '0;
              r_tx     <= 1'b0;
              r_tx_cnt <= CW'(1);
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_CMD;
            end
          end else begin
            r_tx     <= r_tx_sh[0];
            r_tx_cnt <= CW'(1);
          end
        end else if (r_tx_cnt == DIV_LAST) begin
          r_tx_cnt <= '0;
          r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
          r_tx_bit <= r_tx_bit + 1'b1;
        end else r_tx_cnt <= r_tx_cnt + 1'b1;
        default: r_state <= S_CMD;
      endcase
    end
endmodule
